// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem address, IF/ID pipeline register and debug counters.
// Optional FETCH_DELAY_SLOT_EN: on a redirect the IF instruction becomes the delay slot instead of a bubble.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stop,
  input  logic        id_branch,
  input  logic [31:0] id_branch_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [31:0] r_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic        w_redirect;
  logic        w_stall;
  logic [31:0] w_target;

  // Redirect outranks stall, so a stall request is dropped in a redirect cycle.
  assign w_redirect = id_branch;
  assign w_stall    = if_stop & ~id_branch;
  assign w_target   = {id_branch_target[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_id_pc     <= 32'h0;
      r_id_inst   <= NOP_INST;
      r_id_valid  <= 1'b0;
      r_stall_cnt <= 16'h0;
      r_flush_cnt <= 16'h0;
    end else if (w_redirect) begin
      r_pc <= w_target;
`ifdef FETCH_DELAY_SLOT_EN
      r_id_pc    <= r_pc;
      r_id_inst  <= imem_rdata;
      r_id_valid <= 1'b1;
`else
      r_id_pc    <= 32'h0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
`endif
      if (r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end else if (w_stall) begin
      r_id_pc    <= 32'h0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
      if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_pc       <= r_pc + 32'd4;
      r_id_pc    <= r_pc;
      r_id_inst  <= imem_rdata;
      r_id_valid <= 1'b1;
    end
  end

  assign imem_addr = r_pc;
  assign if_pc     = r_pc;
  assign if_inst   = imem_rdata;
  assign id_pc     = r_id_pc;
  assign id_inst   = r_id_inst;
  assign id_valid  = r_id_valid;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IF/ID contents queued at drive time, compared after the edge.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        vld;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, if_stop, id_branch;
  logic [31:0] id_branch_target, imem_rdata;
  logic [31:0] imem_addr, if_pc, if_inst, id_pc, id_inst;
  logic        id_valid;
  logic [15:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_err = 0;
  exp_t q[$];
  logic [31:0] m_pc;
  logic [15:0] m_st, m_fl;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = rom(imem_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst), .if_stop(if_stop), .id_branch(id_branch),
    .id_branch_target(id_branch_target), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .if_pc(if_pc), .if_inst(if_inst),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic br,
                      input logic [31:0] tgt, input bit do_chk);
    exp_t e;
    @(negedge clk);
    rst = r; if_stop = st; id_branch = br; id_branch_target = tgt;
    if (r) begin
      e = '{32'h0, NOP, 1'b0};
      m_pc = RST_PC; m_st = 16'h0; m_fl = 16'h0;
    end else if (br) begin
`ifdef FETCH_DELAY_SLOT_EN
      e = '{m_pc, rom(m_pc), 1'b1};
`else
      e = '{32'h0, NOP, 1'b0};
`endif
      m_pc = {tgt[31:2], 2'b00};
      if (m_fl != 16'hFFFF) m_fl++;
    end else if (st) begin
      e = '{32'h0, NOP, 1'b0};
      if (m_st != 16'hFFFF) m_st++;
    end else begin
      e = '{m_pc, rom(m_pc), 1'b1};
      m_pc = m_pc + 32'd4;
    end
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    if (do_chk) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("if_pc", if_pc, m_pc);
      chk("if_inst", if_inst, rom(m_pc));
      chk("id_pc", id_pc, e.pc);
      chk("id_inst", id_inst, e.inst);
      chk("id_valid", {31'h0, id_valid}, {31'h0, e.vld});
      chk("stall_cnt", {16'h0, stall_cnt}, {16'h0, m_st});
      chk("flush_cnt", {16'h0, flush_cnt}, {16'h0, m_fl});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_err++;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_stop = 1'b0; id_branch = 1'b0; id_branch_target = 32'h0;
    m_pc = RST_PC; m_st = 16'h0; m_fl = 16'h0;

    // reset, then free-running fetch
    step(1, 0, 0, 32'h0, 1);
    chk("rst_addr", imem_addr, 32'h0040_0000);
    chk("rst_inst", id_inst, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    chk("adv1", imem_addr, 32'h0040_0004);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("adv3", imem_addr, 32'h0040_000C);
    chk("adv3_idpc", id_pc, 32'h0040_0008);
    step(0, 0, 0, 32'h0, 1);

    // 3-cycle stall at 0x0040_0010
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 1);
    chk("stall_hold", imem_addr, 32'h0040_0010);
    chk("stall_cnt3", {16'h0, stall_cnt}, 32'd3);
    step(0, 0, 0, 32'h0, 1);
    chk("stall_release", id_pc, 32'h0040_0010);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1);

    // redirect at 0x0040_0020 to unaligned target
    chk("pre_br_pc", imem_addr, 32'h0040_0020);
    step(0, 0, 1, 32'h0040_0103, 1);
    chk("br_target", imem_addr, 32'h0040_0100);
    chk("flush1", {16'h0, flush_cnt}, 32'd1);
    step(0, 0, 0, 32'h0, 1);
    chk("br_first", id_pc, 32'h0040_0100);

    // simultaneous stall + redirect
    step(0, 1, 1, 32'h0040_0200, 1);
    chk("simul_stall", {16'h0, stall_cnt}, 32'd3);
    chk("simul_flush", {16'h0, flush_cnt}, 32'd2);

    // random mix
    for (int i = 0; i < 40; i++)
      step(0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
           $urandom, 1);

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFE, 1);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0, 1);
    chk("wrap", imem_addr, 32'h0);

    // stall counter saturation
    for (int i = 0; i < 70000; i++) step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 1);
    chk("stall_sat", {16'h0, stall_cnt}, 32'h0000_FFFF);

    // reset during stall, then during redirect
    step(1, 1, 0, 32'h0, 1);
    chk("rst_stall_pc", imem_addr, RST_PC);
    chk("rst_stall_cnt", {16'h0, stall_cnt}, 32'd0);
    step(0, 0, 0, 32'h0, 1);
    step(1, 0, 1, 32'h0000_8000, 1);
    chk("rst_br_pc", imem_addr, RST_PC);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the static pipeline CPU: holds the PC, drives the instruction-memory address, presents the fetched word to the hazard judger as `if_inst`, and loads the IF/ID pipeline register. It consumes the judger's `if_stop` (hold PC, inject bubble) and the ID stage's taken-branch redirect (`id_branch`, `id_branch_target`). It also keeps saturating stall and flush counters for debug.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0000, word injected into ID as a bubble

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_stop  in  1  stall request from hazard judger
- id_branch  in  1  taken branch/jump resolved in ID this cycle
- id_branch_target  in  32  redirect address, valid when id_branch=1
- imem_rdata  in  32  instruction word at imem_addr (asynchronous ROM, same cycle)
- imem_addr  out  32  fetch address (= pc)
- if_pc  out  32  PC of instruction currently in IF (= pc)
- if_inst  out  32  instruction currently in IF (= imem_rdata), to hazard judger
- id_pc  out  32  IF/ID register: PC
- id_inst  out  32  IF/ID register: instruction
- id_valid  out  1  IF/ID register holds a real instruction (0 = bubble)
- stall_cnt  out  16  cycles with stall applied, saturating
- flush_cnt  out  16  branch redirects taken, saturating

## Operation
- Per-cycle action chosen by priority: rst > redirect (id_branch) > stall (if_stop) > advance.
- Reset: pc=RESET_PC; id_inst=NOP_INST, id_pc=0, id_valid=0; counters=0.
- Redirect: pc <= {id_branch_target[31:2],2'b00}; IF/ID per Configuration; flush_cnt+1 (sat). if_stop ignored that cycle.
- Stall: pc holds; IF/ID <= bubble (NOP_INST, id_pc=0, id_valid=0); stall_cnt+1 (sat). Held instruction re-presented on if_inst next cycle.
- Advance: pc <= pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0); IF/ID <= {if_pc, imem_rdata, valid=1}.
- Counters saturate at 16'hFFFF, no wrap; cleared only by rst.
- pc[1:0] is always 00.

## Timing
- imem_addr, if_pc, if_inst combinational from pc/imem_rdata; zero latency.
- IF/ID outputs registered; instruction fetched in cycle N visible on id_* in N+1.
- Stall lasting k cycles: pc constant k cycles, k bubbles into ID, instruction enters ID on first cycle after if_stop falls.
- Redirect in cycle N: imem_addr=target in N+1; first target instruction in ID at N+2.
- if_stop and id_branch together: redirect wins, stall_cnt not incremented.
- rst asserted mid-stall or mid-redirect: reset values next edge, pending redirect discarded.
- Outputs after reset edge: imem_addr=if_pc=RESET_PC, id_valid=0, id_inst=NOP_INST, id_pc=0, stall_cnt=flush_cnt=0.

## Configuration
- Macro FETCH_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot; on redirect the IF instruction (slot) is loaded into IF/ID as valid ({if_pc, imem_rdata, 1}).
- Undefined: no delay slot; on redirect IF/ID <= bubble (flush). flush_cnt counts redirects in both builds.

## Test plan
- Reset: rst=1 one cycle -> imem_addr=0x0040_0000, id_valid=0, id_inst=0, counters 0; three free cycles -> imem_addr 0x0040_0004, 0x0040_0008, 0x0040_000C, id_pc trails by one cycle.
- Stall: if_stop=1 for 3 cycles at pc=0x0040_0010 -> pc holds 0x0040_0010, three bubbles (id_valid=0), stall_cnt=3, then id_pc=0x0040_0010 id_valid=1.
- Redirect: id_branch=1, target=0x0040_0103 at pc=0x0040_0020 -> next imem_addr=0x0040_0100; id_valid=0 (no macro) or id_pc=0x0040_0020 valid (FETCH_DELAY_SLOT_EN); flush_cnt=1.
- Simultaneous: if_stop=1 and id_branch=1 same cycle -> redirect taken, stall_cnt unchanged, flush_cnt+1.
- Wrap/saturation: force pc=0xFFFF_FFFC, advance -> imem_addr=0; hold if_stop for 70000 cycles -> stall_cnt=0xFFFF.
- Reset during stall: if_stop=1, rst=1 -> pc=RESET_PC, stall_cnt=0 next edge.
